// File: rtl/if_fetch_queue.sv
// if_fetch_queue: DEPTH-entry in-order fetch queue between pre-IF and ID, with flush cancel counting.
// Latency: data_ok at edge k (or exception push at edge k) makes the entry offerable in cycle k+1.
// Backpressure: fs_allowin drops while queued + cancelled in-flight requests reach DEPTH; head held while ds_allowin low.
module if_fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ps_to_fs_valid,
  input  logic [PC_W-1:0]   ps_to_fs_pc,
  input  logic [2:0]        ps_to_fs_ex,
  output logic              fs_allowin,
  input  logic              inst_sram_data_ok,
  input  logic [INST_W-1:0] inst_sram_rdata,
  input  logic              flush,
  input  logic              has_int,
  input  logic              ds_allowin,
  output logic              fs_to_ds_valid,
  output logic [PC_W-1:0]   fs_to_ds_pc,
  output logic [INST_W-1:0] fs_to_ds_inst,
  output logic              fs_to_ds_ex,
  output logic [4:0]        fs_to_ds_exccode,
  output logic [PC_W-1:0]   fs_to_ds_badvaddr,
  output logic              fs_to_ds_tlb_refill,
  output logic              fs_idle
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]   pc_q   [DEPTH];
  logic [PC_W-1:0]   pc_d   [DEPTH];
  logic [2:0]        ex_q   [DEPTH];
  logic [2:0]        ex_d   [DEPTH];
  logic [INST_W-1:0] inst_q [DEPTH];
  logic [INST_W-1:0] inst_d [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d, done_q, done_d;
  logic [AW-1:0]     head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d, cancel_q, cancel_d;

  logic [CW:0]       occ;
  logic [CW-1:0]     pend_cnt;
  logic              push, pop, n_issue, head_vld;
  logic [2:0]        head_ex;

  // Queued entries plus responses still owed to cancelled requests bound the in-flight total.
  assign occ        = {1'b0, count_q} + {1'b0, cancel_q};
  assign fs_allowin = (occ < (CW+1)'(DEPTH));
  assign push       = ps_to_fs_valid & fs_allowin & ~flush;
  assign pop        = fs_to_ds_valid & ds_allowin;
  // A non-exception fetch presented while we accept was issued to sram even if a flush drops it.
  assign n_issue    = ps_to_fs_valid & fs_allowin & ~(|ps_to_fs_ex);

  // Head view; stale slots beyond the valid region must not leak exception bits.
  assign head_vld            = vld_q[head_q];
  assign head_ex             = head_vld ? ex_q[head_q] : 3'b000;
  assign fs_to_ds_valid      = head_vld & done_q[head_q] & ~flush;
  assign fs_to_ds_pc         = pc_q[head_q];
  assign fs_to_ds_badvaddr   = pc_q[head_q];
  assign fs_to_ds_ex         = has_int | (|head_ex);
  assign fs_to_ds_inst       = fs_to_ds_ex ? '0 : inst_q[head_q];
  assign fs_to_ds_tlb_refill = head_ex[1];
  assign fs_to_ds_exccode    = has_int                   ? 5'h00 :
                               (head_ex[1] | head_ex[0]) ? 5'h02 :
                               head_ex[2]                ? 5'h04 : 5'h00;
  assign fs_idle             = (count_q == '0) && (cancel_q == '0);

  // Count entries still waiting on sram data; these become cancelled requests on flush.
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt = pend_cnt + CW'(vld_q[i] & ~done_q[i]);
    end
  end

  // Next-state: flush bookkeeping, or response fill / pop / push with fill-pointer advance.
  always_comb begin
    pc_d     = pc_q;
    ex_d     = ex_q;
    inst_d   = inst_q;
    vld_d    = vld_q;
    done_d   = done_q;
    head_d   = head_q;
    fill_d   = fill_q;
    tail_d   = tail_q;
    count_d  = count_q;
    cancel_d = cancel_q;
    if (flush) begin
      vld_d   = '0;
      done_d  = '0;
      head_d  = '0;
      fill_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // A data_ok this cycle retires one owed response, old cancels first then pending entries.
      cancel_d = cancel_q + pend_cnt + CW'(n_issue)
               - CW'(inst_sram_data_ok && ((cancel_q != '0) || (pend_cnt != '0)));
    end else begin
      if (inst_sram_data_ok) begin
        if (cancel_q != '0) begin
          cancel_d = cancel_q - CW'(1);
        end else if (vld_q[fill_q] && !done_q[fill_q]) begin
          inst_d[fill_q] = inst_sram_rdata;
          done_d[fill_q] = 1'b1;
        end
      end
      if (pop) begin
        vld_d[head_q] = 1'b0;
        head_d        = head_q + AW'(1);
      end
      if (push) begin
        pc_d[tail_q]   = ps_to_fs_pc;
        ex_d[tail_q]   = ps_to_fs_ex;
        inst_d[tail_q] = '0;
        vld_d[tail_q]  = 1'b1;
        done_d[tail_q] = |ps_to_fs_ex;
        tail_d         = tail_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      // Fill parks at tail when nothing is pending, else walks to the oldest entry awaiting data.
      if ((vld_d & ~done_d) == '0) begin
        fill_d = tail_d;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (vld_d[fill_d] && done_d[fill_d]) fill_d = fill_d + AW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        ex_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      vld_q    <= '0;
      done_q   <= '0;
      head_q   <= '0;
      fill_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      cancel_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ex_q     <= ex_d;
      inst_q   <= inst_d;
      vld_q    <= vld_d;
      done_q   <= done_d;
      head_q   <= head_d;
      fill_q   <= fill_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      cancel_q <= cancel_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic against a queue-level reference model.
// Stimulus pushes expected ID handoffs into a scoreboard; a negedge monitor pops and compares.
// All waits are bounded by a global time limit.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ps_to_fs_valid;
  logic [31:0] ps_to_fs_pc;
  logic [2:0]  ps_to_fs_ex;
  logic        fs_allowin;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        flush;
  logic        has_int;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [31:0] fs_to_ds_pc;
  logic [31:0] fs_to_ds_inst;
  logic        fs_to_ds_ex;
  logic [4:0]  fs_to_ds_exccode;
  logic [31:0] fs_to_ds_badvaddr;
  logic        fs_to_ds_tlb_refill;
  logic        fs_idle;

  if_fetch_queue #(.DEPTH(DEPTH), .PC_W(32), .INST_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .ps_to_fs_valid(ps_to_fs_valid), .ps_to_fs_pc(ps_to_fs_pc), .ps_to_fs_ex(ps_to_fs_ex),
    .fs_allowin(fs_allowin),
    .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .flush(flush), .has_int(has_int), .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_pc(fs_to_ds_pc), .fs_to_ds_inst(fs_to_ds_inst),
    .fs_to_ds_ex(fs_to_ds_ex), .fs_to_ds_exccode(fs_to_ds_exccode),
    .fs_to_ds_badvaddr(fs_to_ds_badvaddr), .fs_to_ds_tlb_refill(fs_to_ds_tlb_refill),
    .fs_idle(fs_idle)
  );

  always #5 clk = ~clk;

  // Reference model: the queue contents as a list of fetches, plus responses still owed.
  typedef struct {
    logic [31:0] pc;
    logic [2:0]  ex;
    logic [31:0] inst;
    bit          done;
  } ment_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        ex;
    logic [4:0]  code;
    logic        refill;
  } exp_t;

  ment_t mq[$];
  int    mcancel;
  exp_t  expq[$];
  logic  exp_valid, exp_allow, exp_idle;
  bit    chk_en;
  int    n_cmp, n_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: per-cycle handshake checks and scoreboard pops on every ID acceptance.
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      check("fs_to_ds_valid", fs_to_ds_valid, exp_valid);
      check("fs_allowin", fs_allowin, exp_allow);
      check("fs_idle", fs_idle, exp_idle);
      if (fs_to_ds_valid && ds_allowin) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_pop: got pc %0h, expected no handoff", fs_to_ds_pc);
        end else begin
          e = expq.pop_front();
          check("pc", fs_to_ds_pc, e.pc);
          check("badvaddr", fs_to_ds_badvaddr, e.pc);
          check("inst", fs_to_ds_inst, e.inst);
          check("ex", fs_to_ds_ex, e.ex);
          check("exccode", fs_to_ds_exccode, e.code);
          check("tlb_refill", fs_to_ds_tlb_refill, e.refill);
        end
      end
    end
  end

  // Drive one cycle of inputs, advance the model over the coming edge, then step the clock.
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [2:0] ex,
                       input logic dok, input logic [31:0] rd,
                       input logic fl, input logic hi, input logic da);
    bit    allow, offer, pop, found;
    int    p;
    exp_t  e;
    ment_t t;
    ps_to_fs_valid    = v;
    ps_to_fs_pc       = pc;
    ps_to_fs_ex       = ex;
    inst_sram_data_ok = dok;
    inst_sram_rdata   = rd;
    flush             = fl;
    has_int           = hi;
    ds_allowin        = da;

    allow     = (mq.size() + mcancel) < DEPTH;
    offer     = (mq.size() > 0) && mq[0].done && !fl;
    pop       = offer && da;
    exp_valid = offer;
    exp_allow = allow;
    exp_idle  = (mq.size() == 0) && (mcancel == 0);

    if (pop) begin
      e.pc     = mq[0].pc;
      e.ex     = hi || (mq[0].ex != 3'b000);
      if (hi)                            e.code = 5'h00;
      else if (mq[0].ex[1] || mq[0].ex[0]) e.code = 5'h02;
      else if (mq[0].ex[2])              e.code = 5'h04;
      else                               e.code = 5'h00;
      e.inst   = e.ex ? 32'h0 : mq[0].inst;
      e.refill = mq[0].ex[1];
      expq.push_back(e);
    end

    if (fl) begin
      p = 0;
      foreach (mq[i]) if (!mq[i].done) p++;
      mcancel = mcancel + p + ((v && allow && ex == 3'b000) ? 1 : 0)
              - ((dok && (mcancel + p) > 0) ? 1 : 0);
      mq.delete();
    end else begin
      if (dok) begin
        if (mcancel > 0) begin
          mcancel--;
        end else begin
          found = 0;
          for (int i = 0; i < mq.size(); i++) begin
            if (!found && !mq[i].done) begin
              t = mq[i];
              t.inst = rd;
              t.done = 1;
              mq[i] = t;
              found = 1;
            end
          end
        end
      end
      if (pop) void'(mq.pop_front());
      if (v && allow) begin
        t.pc   = pc;
        t.ex   = ex;
        t.inst = 32'h0;
        t.done = (ex != 3'b000);
        mq.push_back(t);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cycle(1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic push_cyc(input logic [31:0] pc, input logic [2:0] ex);
    cycle(1'b1, pc, ex, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic data_cyc(input logic [31:0] rd);
    cycle(1'b0, 32'h0, 3'b000, 1'b1, rd, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int outs;
    logic v, dok, fl, hi, da;
    logic [2:0] ex;
    n_cmp = 0;
    n_bad = 0;
    chk_en = 0;
    mcancel = 0;
    resetn = 1'b0;
    ps_to_fs_valid = 0; ps_to_fs_pc = '0; ps_to_fs_ex = '0;
    inst_sram_data_ok = 0; inst_sram_rdata = '0;
    flush = 0; has_int = 0; ds_allowin = 0;
    #12;
    check("reset_valid", fs_to_ds_valid, 1'b0);
    check("reset_allowin", fs_allowin, 1'b1);
    check("reset_idle", fs_idle, 1'b1);
    check("reset_pc", fs_to_ds_pc, 32'h0);
    check("reset_inst", fs_to_ds_inst, 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1;

    // Three fetches, three in-order responses, back-to-back handoff.
    push_cyc(32'h1000, 3'b000);
    push_cyc(32'h1004, 3'b000);
    push_cyc(32'h1008, 3'b000);
    data_cyc(32'hA);
    data_cyc(32'hB);
    data_cyc(32'hC);
    idle_cyc();
    idle_cyc();

    // Fill with four outstanding, flush, drop four stale responses, keep the fifth.
    for (int i = 0; i < 4; i++) push_cyc(32'h1100 + 32'(i * 4), 3'b000);
    push_cyc(32'h1200, 3'b000);
    cycle(1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    check("flush_count", dut.count_q, 3'd0);
    check("flush_cancel4", dut.cancel_q, 3'd4);
    data_cyc(32'hDEAD0001);
    cycle(1'b1, 32'h2000, 3'b000, 1'b1, 32'hDEAD0002, 1'b0, 1'b0, 1'b1);
    data_cyc(32'hDEAD0003);
    data_cyc(32'hDEAD0004);
    data_cyc(32'h55);
    idle_cyc();

    // Flush coinciding with a fresh issue and a data_ok while two entries are pending.
    push_cyc(32'h5000, 3'b000);
    push_cyc(32'h5004, 3'b000);
    cycle(1'b1, 32'h5008, 3'b000, 1'b1, 32'hBAD, 1'b1, 1'b0, 1'b1);
    check("flush_cancel2", dut.cancel_q, 3'd2);
    data_cyc(32'hBAD1);
    data_cyc(32'hBAD2);
    idle_cyc();

    // Exception fetches complete without any sram response.
    push_cyc(32'h3001, 3'b100);
    push_cyc(32'h3004, 3'b010);
    push_cyc(32'h3008, 3'b001);
    idle_cyc();
    idle_cyc();

    // Interrupt-tagged head held under backpressure, then exactly one pop.
    push_cyc(32'h4000, 3'b000);
    data_cyc(32'h77);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    idle_cyc();
    idle_cyc();

    // Asynchronous reset with three queued entries and one cancelled response owed.
    push_cyc(32'h6000, 3'b000);
    cycle(1'b0, 32'h0, 3'b000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    push_cyc(32'h6004, 3'b000);
    push_cyc(32'h6008, 3'b000);
    push_cyc(32'h600C, 3'b000);
    check("pre_reset_count", dut.count_q, 3'd3);
    check("pre_reset_cancel", dut.cancel_q, 3'd1);
    ps_to_fs_valid = 0; inst_sram_data_ok = 0; flush = 0; has_int = 0;
    chk_en = 0;
    #2;
    resetn = 1'b0;
    #1;
    check("arst_count", dut.count_q, 3'd0);
    check("arst_cancel", dut.cancel_q, 3'd0);
    check("arst_valid", fs_to_ds_valid, 1'b0);
    check("arst_allowin", fs_allowin, 1'b1);
    check("arst_idle", fs_idle, 1'b1);
    @(negedge clk);
    resetn = 1'b1;
    mq.delete();
    expq.delete();
    mcancel = 0;
    @(posedge clk);
    #1;
    chk_en = 1;
    data_cyc(32'hF00D);
    push_cyc(32'h7000, 3'b000);
    data_cyc(32'h99);
    idle_cyc();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      outs = mcancel;
      foreach (mq[i]) if (!mq[i].done) outs++;
      v   = ($urandom_range(0, 3) != 0);
      ex  = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      dok = (outs > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 49) == 0);
      fl  = ($urandom_range(0, 24) == 0);
      hi  = ($urandom_range(0, 14) == 0);
      da  = ($urandom_range(0, 3) != 0);
      cycle(v, $urandom & 32'hFFFF_FFFC, ex, dok, $urandom, fl, hi, da);
    end

    // Drain everything still owed or queued.
    for (int c = 0; c < 20; c++) begin
      outs = mcancel;
      foreach (mq[i]) if (!mq[i].done) outs++;
      cycle(1'b0, 32'h0, 3'b000, (outs > 0), $urandom, 1'b0, 1'b0, 1'b1);
    end
    chk_en = 0;
    check("scoreboard_empty", 64'(expq.size()), 64'd0);
    check("final_idle", fs_idle, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage sitting between the pre-IF stage (which issues inst_sram requests) and ID. It generalises the single-slot fetch buffer to a DEPTH-entry in-order queue, tracking several outstanding inst_sram requests. It discards stale responses after a flush using a multi-bit cancel counter instead of a one-bit cancel flag. Per-entry fetch exceptions (ADEL, TLB refill, TLB invalid) and an interrupt tag are attached to the instruction handed to ID.

## Interface
- DEPTH, 4, queue entries and max in-flight requests; power of two, ≥2
- PC_W, 32, PC / badvaddr width
- INST_W, 32, instruction width
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- ps_to_fs_valid  in  1  pre-IF presents a fetch; non-exception fetches were issued to inst_sram this cycle
- ps_to_fs_pc  in  PC_W  fetch PC
- ps_to_fs_ex  in  3  {pc_adel, tlb_miss, tlb_invalid}; any bit set ⇒ no sram request was issued
- fs_allowin  out  1  queue accepts a fetch this cycle
- inst_sram_data_ok  in  1  one in-order response
- inst_sram_rdata  in  INST_W  response data
- flush  in  1  handle_exc | handle_eret | pipe_flush
- has_int  in  1  pending interrupt, tagged onto the head at output
- ds_allowin  in  1  ID accepts
- fs_to_ds_valid  out  1  head entry complete and offered
- fs_to_ds_pc  out  PC_W  head PC
- fs_to_ds_inst  out  INST_W  head instruction; 0 when fs_to_ds_ex
- fs_to_ds_ex  out  1  has_int | any head ex bit
- fs_to_ds_exccode  out  5  priority INT(0x00) > TLBL(0x02) > ADEL(0x04); 0 if no ex
- fs_to_ds_badvaddr  out  PC_W  = head PC
- fs_to_ds_tlb_refill  out  1  head tlb_miss (selects refill vector)
- fs_idle  out  1  queue empty and cancel_cnt == 0

## Operation
- Storage: DEPTH entries {pc, ex[2:0], inst, done}. Three pointers: head (pop), fill (oldest entry awaiting data), tail (push). Each pointer is log2(DEPTH) bits and wraps modulo DEPTH. count and cancel_cnt are log2(DEPTH)+1 bits.
- Accept condition: fs_allowin = (count + cancel_cnt < DEPTH). It has no dependence on ds_allowin or on a pop in the same cycle.
- Push, when ps_to_fs_valid & fs_allowin & !flush:
  - write the entry at tail; tail++, count++
  - done = 1 immediately if ex ≠ 0
  - the fill pointer skips done entries
- Response, when data_ok:
  - if cancel_cnt > 0: drop it, cancel_cnt--
  - else if a non-done entry exists: write inst at fill, set done, advance fill past done entries
  - else: ignore (spurious)
- Pop: fs_to_ds_valid = head.done & count > 0 & !flush. On fs_to_ds_valid & ds_allowin: head++, count--.
- Flush:
  - all entries invalidated; count, head, fill, tail ← 0
  - cancel_cnt ← cancel_cnt + P + N − D, where:
    - P = non-done, non-ex entries
    - N = 1 if a non-ex fetch is presented with fs_allowin this cycle (it was issued, so it is counted, not enqueued)
    - D = 1 if data_ok this cycle
  - a data_ok in the flush cycle is consumed against the old cancel_cnt first, then against pending entries. The formula above covers both cases.
- Push and pop in the same cycle: count unchanged.
- Push and data_ok for the same entry in the same cycle is impossible: data arrives no earlier than the cycle after issue.

## Timing
- Reset (resetn low, asynchronous):
  - pointers, count, cancel_cnt, all done bits ← 0
  - fs_to_ds_valid = 0, fs_allowin = 1, fs_idle = 1
  - data outputs 0
- Latency: data_ok at edge k ⇒ entry done after edge k ⇒ offered in cycle k+1 if at head. An exception fetch pushed at edge k is offered in cycle k+1.
- Outputs are combinational from registered state, except:
  - fs_to_ds_valid is gated by flush
  - ex/exccode include has_int combinationally
- Throughput: 1 instruction/cycle in steady state with ≥2 requests in flight.
- In-flight bound: count + cancel_cnt never exceeds DEPTH; no counter overflow.

## Test plan
- DEPTH=4: push PCs 0x1000, 0x1004, 0x1008; data_ok ×3 with 0xA, 0xB, 0xC; ds_allowin=1 → ID receives (0x1000,0xA), (0x1004,0xB), (0x1008,0xC) on consecutive cycles; fs_idle=1 afterwards.
- Fill 4 non-ex fetches with no responses → fs_allowin=0. Flush → count=0, cancel_cnt=4. Push 0x2000. Four data_ok are dropped; the fifth (0x55) → ID gets (0x2000, 0x55).
- Flush coincident with a non-ex push and a data_ok, with 2 entries pending → cancel_cnt=2, fs_to_ds_valid=0 that cycle.
- Push 0x3001 with ex=pc_adel, then 0x3004 with tlb_miss → offered in order:
  - first: exccode 0x04, inst 0, badvaddr 0x3001
  - second: exccode 0x02, tlb_refill=1
  - no data_ok needed
- Head valid with has_int=1 and ds_allowin=0 for 3 cycles → valid held, exccode 0x00. Then ds_allowin=1 → single pop.
- Assert resetn low mid-operation with 3 entries and cancel_cnt=1 → all state 0 immediately; after release fs_allowin=1, fs_idle=1, stray data_ok ignored.
